// File: rtl/boot_loader_pkg.sv
// Boot-state encodings shared with the boot FSM, and the loader state set.
package boot_loader_pkg;

  typedef enum logic [1:0] {
    BS_OFF    = 2'b00,
    BS_FIRST  = 2'b01,
    BS_SECOND = 2'b10,
    BS_NORMAL = 2'b11
  } boot_state_e;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_READ,
    LD_LATCH,
    LD_WRITE,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

endpackage

// File: rtl/boot_wait_timer.sv
// Per-word IMEM handshake timer: counts stalled cycles, flags the final one.
module boot_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted on the stalled edge that brings the count to TIMEOUT.
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/boot_loader.sv
// Copies the boot ROM image into IMEM once boot state is NORMAL, then
// releases the core from reset.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WORDS    = 64,
  parameter int unsigned ROM_BASE = 0,
  parameter int unsigned MEM_BASE = 0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        boot_state,
  output logic              rom_re,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              cpu_rst_n,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  ld_state_e         state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rom_re_q, rom_re_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_err_q, boot_err_d;
  logic              normal;
  logic              wait_expired;

  assign normal = (boot_state == BS_NORMAL);

  boot_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != LD_WRITE),
    .en      ((state_q == LD_WRITE) && !mem_ready),
    .expired (wait_expired)
  );

  // Next state, word count and registered outputs (decoded from next state).
  always_comb begin
    state_d = state_q;
    count_d = count_q;

    case (state_q)
      LD_IDLE:  if (normal) state_d = LD_READ;
      LD_READ:  state_d = normal ? LD_LATCH : LD_IDLE;
      LD_LATCH: state_d = normal ? LD_WRITE : LD_IDLE;
      LD_WRITE: begin
        if (!normal) begin
          state_d = LD_IDLE;
        end else if (mem_ready) begin
          if (count_q == CW'(WORDS - 1)) begin
            state_d = LD_DONE;
          end else begin
            count_d = count_q + CW'(1);
            state_d = LD_READ;
          end
        end else if (wait_expired) begin
          state_d = LD_ERROR;
        end
      end
      LD_DONE:  if (!normal) state_d = LD_IDLE;
      LD_ERROR: state_d = LD_ERROR;
      default:  state_d = LD_IDLE;
    endcase

    if (state_d == LD_IDLE) count_d = '0;

    rom_re_d   = (state_d == LD_READ);
    rom_addr_d = rom_addr_q;
    if (state_d == LD_READ) rom_addr_d = ADDR_W'(ROM_BASE) + ADDR_W'(count_d);

    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if ((state_q == LD_LATCH) && (state_d == LD_WRITE)) begin
      mem_wdata_d = rom_rdata;
      mem_addr_d  = ADDR_W'(MEM_BASE) + ADDR_W'(count_q);
    end

    mem_we_d    = (state_d == LD_WRITE);
    cpu_rst_n_d = (state_d == LD_DONE);
    boot_done_d = (state_d == LD_DONE);
    boot_err_d  = (state_d == LD_ERROR);
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LD_IDLE;
      count_q     <= '0;
      rom_re_q    <= 1'b0;
      rom_addr_q  <= ADDR_W'(ROM_BASE);
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_W'(MEM_BASE);
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rom_re_q    <= rom_re_d;
      rom_addr_q  <= rom_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      boot_done_q <= boot_done_d;
      boot_err_q  <= boot_err_d;
    end
  end

  assign rom_re    = rom_re_q;
  assign rom_addr  = rom_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign boot_done = boot_done_q;
  assign boot_err  = boot_err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: WORDS=4 main instance plus a WORDS=1 instance.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    boot_state;
  logic          rom_re;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic          cpu_rst_n, boot_done, boot_err;

  logic [1:0]    bs1;
  logic          rom_re1;
  logic [AW-1:0] rom_addr1;
  logic [DW-1:0] rom_rdata1;
  logic          mem_we1;
  logic [AW-1:0] mem_addr1;
  logic [DW-1:0] mem_wdata1;
  logic          mem_ready1;
  logic          cpu_rst_n1, boot_done1, boot_err1;

  always #5 clk = ~clk;

  boot_loader #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS(4), .ROM_BASE(0), .MEM_BASE(0), .TIMEOUT(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .boot_state(boot_state),
    .rom_re(rom_re), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .cpu_rst_n(cpu_rst_n), .boot_done(boot_done), .boot_err(boot_err)
  );

  boot_loader #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS(1), .ROM_BASE(0), .MEM_BASE(0), .TIMEOUT(16)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .boot_state(bs1),
    .rom_re(rom_re1), .rom_addr(rom_addr1), .rom_rdata(rom_rdata1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_ready(mem_ready1),
    .cpu_rst_n(cpu_rst_n1), .boot_done(boot_done1), .boot_err(boot_err1)
  );

  function automatic logic [DW-1:0] rom_word(input int i);
    return DW'(32'hA0 + i);
  endfunction

  // Synchronous ROMs; data outside a read cycle is junk so a mistimed latch shows.
  always @(posedge clk) rom_rdata  <= rom_re  ? rom_word(int'(rom_addr))  : 32'hDEAD_BEEF;
  always @(posedge clk) rom_rdata1 <= rom_re1 ? rom_word(int'(rom_addr1)) : 32'hDEAD_BEEF;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int stall_word;
    int stall_len;
    int exp_edges;
    bit exp_err;
    int exp_rom_re;
  } vec_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cur_stall = -1;
  int  rom_re_cnt = 0;
  int  done_rise = 0;
  logic done_prev = 1'b0;
  int  wr1_cnt = 0;
  logic [AW-1:0] wr1_addr = '0;
  logic [DW-1:0] wr1_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted IMEM write must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {24'h0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {24'h0, mem_addr}, {24'h0, e.addr});
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  // While a word is stalled its address and data must not move.
  always @(negedge clk) begin
    if (rst_n && mem_we && !mem_ready && cur_stall >= 0) begin
      chk("stall_addr", {24'h0, mem_addr}, 32'(cur_stall));
      chk("stall_data", mem_wdata, rom_word(cur_stall));
    end
  end

  always @(negedge clk) begin
    if (rom_re) rom_re_cnt <= rom_re_cnt + 1;
    if (boot_done && !done_prev) done_rise <= done_rise + 1;
    done_prev <= boot_done;
    if (rst_n && mem_we1 && mem_ready1) begin
      wr1_cnt  <= wr1_cnt + 1;
      wr1_addr <= mem_addr1;
      wr1_data <= mem_wdata1;
    end
  end

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_rom_re"},    rom_re, 0);
    chk({pfx, "_rom_addr"},  {24'h0, rom_addr}, 0);
    chk({pfx, "_mem_we"},    mem_we, 0);
    chk({pfx, "_mem_addr"},  {24'h0, mem_addr}, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
    chk({pfx, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({pfx, "_done"},      boot_done, 0);
    chk({pfx, "_err"},       boot_err, 0);
  endtask

  // Reset, then walk the boot FSM through FIRST and SECOND; ends at posedge+1.
  task automatic do_reset();
    rst_n      = 1'b0;
    boot_state = BS_OFF;
    bs1        = BS_OFF;
    mem_ready  = 1'b1;
    mem_ready1 = 1'b1;
    cur_stall  = -1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 boot_state = BS_FIRST;
    @(posedge clk); #1 boot_state = BS_SECOND;
    @(posedge clk); #1;
    chk("ramp_idle", {30'h0, rom_re, mem_we}, 0);
  endtask

  task automatic push_all(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{addr: AW'(i), data: rom_word(i)});
  endtask

  // Drive NORMAL and count edges until done/err; stall one word if asked.
  task automatic run_copy(input int stall_word, input int stall_len, output int edges);
    int left;
    bit fin;
    left       = stall_len;
    fin        = 1'b0;
    edges      = 0;
    cur_stall  = stall_word;
    boot_state = BS_NORMAL;
    mem_ready  = 1'b1;
    while (!fin && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (boot_done || boot_err) begin
        fin = 1'b1;
      end else if (mem_we && int'(mem_addr) == stall_word && left > 0) begin
        mem_ready = 1'b0;
        left--;
      end else begin
        mem_ready = 1'b1;
      end
    end
    cur_stall = -1;
    mem_ready = 1'b1;
  endtask

  task automatic wait_write_at(input int addr, input string name);
    int n;
    n = 0;
    while (!(mem_we && int'(mem_addr) == addr) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'h0, mem_we && int'(mem_addr) == addr}, 1);
  endtask

  initial begin
    vec_t vecs[5];
    int   edges;
    int   base_re;
    int   base_rise;
    int   base_wr1;
    int   n;

    vecs[0] = '{-1,  0, 13, 1'b0, 4};
    vecs[1] = '{ 2,  5, 18, 1'b0, 4};
    vecs[2] = '{ 0,  1, 14, 1'b0, 4};
    vecs[3] = '{ 3, 15, 28, 1'b0, 4};
    vecs[4] = '{ 1, 16, 22, 1'b1, 2};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      push_all(vecs[v].exp_err ? vecs[v].stall_word : 4);
      base_re = rom_re_cnt;
      run_copy(vecs[v].stall_word, vecs[v].stall_len, edges);
      chk($sformatf("v%0d_edges", v), 32'(edges), 32'(vecs[v].exp_edges));
      chk($sformatf("v%0d_done", v), boot_done, !vecs[v].exp_err);
      chk($sformatf("v%0d_err", v), boot_err, vecs[v].exp_err);
      chk($sformatf("v%0d_cpu_rst_n", v), cpu_rst_n, !vecs[v].exp_err);
      chk($sformatf("v%0d_rom_re", v), 32'(rom_re_cnt - base_re), 32'(vecs[v].exp_rom_re));
      chk($sformatf("v%0d_q_empty", v), 32'(exp_q.size()), 0);
      if (vecs[v].exp_err) begin
        for (int i = 0; i < 8; i++) begin
          mem_ready  = 1'($urandom);
          boot_state = (i % 2 == 1) ? BS_NORMAL : BS_OFF;
          @(posedge clk); #1;
          chk("err_hold", {28'h0, boot_err, cpu_rst_n, mem_we, boot_done}, 32'h8);
        end
        mem_ready = 1'b1;
      end
    end

    // Abort during word 2 and restart from word 0.
    do_reset();
    push_all(4);
    base_rise  = done_rise;
    boot_state = BS_NORMAL;
    mem_ready  = 1'b1;
    wait_write_at(2, "abort_reach");
    mem_ready  = 1'b0;
    boot_state = BS_SECOND;
    @(posedge clk); #1;
    chk("abort_idle", {28'h0, mem_we, boot_done, cpu_rst_n, rom_re}, 0);
    chk("abort_q", 32'(exp_q.size()), 2);
    exp_q.delete();
    push_all(4);
    base_re = rom_re_cnt;
    run_copy(-1, 0, edges);
    chk("abort_edges", 32'(edges), 13);
    chk("abort_done", boot_done, 1);
    chk("abort_rom_re", 32'(rom_re_cnt - base_re), 4);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_done_once", 32'(done_rise - base_rise), 1);
    chk("abort_q_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset while word 1 is stalled in WRITE.
    do_reset();
    push_all(4);
    boot_state = BS_NORMAL;
    mem_ready  = 1'b1;
    wait_write_at(1, "arst_reach");
    mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    chk("arst_q", 32'(exp_q.size()), 3);
    do_reset();
    push_all(4);
    run_copy(-1, 0, edges);
    chk("arst_edges", 32'(edges), 13);
    chk("arst_done", {30'h0, boot_done, cpu_rst_n}, 3);
    chk("arst_q_empty", 32'(exp_q.size()), 0);

    // Single-word instance.
    do_reset();
    base_wr1 = wr1_cnt;
    bs1 = BS_NORMAL;
    n = 0;
    while (!boot_done1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w1_edges", 32'(n), 4);
    chk("w1_cpu_rst_n", cpu_rst_n1, 1);
    chk("w1_writes", 32'(wr1_cnt - base_wr1), 1);
    chk("w1_addr", {24'h0, wr1_addr}, 0);
    chk("w1_data", wr1_data, 32'hA0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
